// File: rtl/scan_query_controller.sv
// rtl/scan_query_controller.sv - scan load / capture / unload sequencer for one oracle query
module scan_query_controller #(
    parameter int CHAIN_LEN = 3,
    parameter int PI_W      = 4,
    parameter int PO_W      = 1,
    parameter int CYC_W     = 4
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] STATE_IN,
    input  logic [PI_W-1:0]      PI_IN,
    input  logic [CYC_W-1:0]     CAP_CYCLES,
    input  logic                 SO,
    input  logic [PO_W-1:0]      DUT_PO,
    output logic                 SE,
    output logic                 SI,
    output logic                 DUT_EN,
    output logic [PI_W-1:0]      DUT_PI,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] STATE_OUT,
    output logic [PO_W-1:0]      PO_OUT
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, FIN} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        bit_cnt;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [CYC_W-1:0]     n_lat;
    logic [PI_W-1:0]      pi_lat;
    logic [CHAIN_LEN-1:0] sh, sh_nxt;
    logic [PO_W-1:0]      po_cap;
    logic                 bit_last, cyc_last;

    assign bit_last = (bit_cnt == LAST_BIT);
    assign cyc_last = (cyc_cnt == n_lat - CYC_W'(1));

    // One register serves both directions: it shifts the load image out MSB first
    // (back-filling zeros) and then collects SO during unload.
    assign sh_nxt = (sh << 1) | CHAIN_LEN'((state == UNLOAD) ? SO : 1'b0);

    always_comb begin
        state_nxt = state;
        SE        = 1'b0;
        SI        = 1'b0;
        DUT_EN    = 1'b0;
        DUT_PI    = '0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE: begin
                if (START) state_nxt = LOAD;
            end
            LOAD: begin
                SE     = 1'b1;
                DUT_EN = 1'b1;
                BUSY   = 1'b1;
                SI     = sh[CHAIN_LEN-1];
                if (bit_last) state_nxt = (n_lat == '0) ? UNLOAD : CAPTURE;
            end
            CAPTURE: begin
                DUT_EN = 1'b1;
                BUSY   = 1'b1;
                DUT_PI = pi_lat;
                if (cyc_last) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                SE     = 1'b1;
                DUT_EN = 1'b1;
                BUSY   = 1'b1;
                if (bit_last) state_nxt = FIN;
            end
            FIN: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            n_lat     <= '0;
            pi_lat    <= '0;
            sh        <= '0;
            po_cap    <= '0;
            STATE_OUT <= '0;
            PO_OUT    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (START) begin
                        sh      <= STATE_IN;
                        pi_lat  <= PI_IN;
                        n_lat   <= CAP_CYCLES;
                        po_cap  <= '0;
                        bit_cnt <= '0;
                        cyc_cnt <= '0;
                    end
                end
                LOAD: begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
                end
                CAPTURE: begin
                    po_cap  <= DUT_PO;
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                end
                UNLOAD: begin
                    sh      <= sh_nxt;
                    bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
                    // Published results change only here, so they hold through the next query.
                    if (bit_last) begin
                        STATE_OUT <= sh_nxt;
                        PO_OUT    <= po_cap;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
